// File: rtl/mem_wb_stage_ext_pkg.sv
// rtl/mem_wb_stage_ext_pkg.sv - shared constants, access-size encodings and FSM states for the MEM stage
package mem_wb_stage_ext_pkg;

  localparam int XLEN_C  = 32;
  localparam int LANES_C = XLEN_C / 8;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic { S_IDLE, S_WAIT } memState_t;

  typedef enum logic [1:0] { SZ_B, SZ_H, SZ_W } accSize_t;

  // Unlisted funct3 codes are treated as full-word accesses.
  function automatic accSize_t accSize(input logic [2:0] f3);
    case (f3)
      LS_B, LS_BU: return SZ_B;
      LS_H, LS_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_wb_stage_ext_byte_en_ram.sv
// rtl/mem_wb_stage_ext_byte_en_ram.sv - single-port RAM, per-lane write enables, combinational read
module byte_en_ram #(
  parameter int XLEN = 32,
  parameter int MEM_DEPTH = 1024,
  localparam int LANES = XLEN / 8,
  localparam int AW = $clog2(MEM_DEPTH)
) (
  input  logic             clk,
  input  logic [LANES-1:0] we,
  input  logic [AW-1:0]    addr,
  input  logic [XLEN-1:0]  wdata,
  output logic [XLEN-1:0]  rdata
);

  logic [XLEN-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (we[l]) mem[addr][8*l +: 8] <= wdata[8*l +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage_ext.sv
// rtl/mem_wb_stage_ext.sv - MEM stage with multi-cycle latency FSM and MEM/WB register; optional MISALIGN_TRAP_EN
module mem_wb_stage_ext
  import mem_wb_stage_ext_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int MEM_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic [4:0]      RdM,
  input  logic            RegWriteM,
  input  logic            MemWriteM,
  input  logic            MemReadM,
  input  logic [1:0]      ResultSrcM,
  input  logic [2:0]      Funct3M,
  input  logic            FlushM,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [XLEN-1:0] PCPlus4W,
  output logic [4:0]      RdW,
  output logic            RegWriteW,
  output logic [1:0]      ResultSrcW,
`ifdef MISALIGN_TRAP_EN
  output logic            MisalignW,
`endif
  output logic            StallM
);

  localparam int LANES = XLEN / 8;
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(MEM_LATENCY + 1);

  memState_t state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic memOp, isStore, isLoad, trap, slowOp, commit;
  accSize_t size;
  logic [AW+1:0] effAddr;
  logic [LANES-1:0] laneMask, ramWe;
  logic [XLEN-1:0] ramWdata, ramRdata, loadExt;
  logic [7:0] laneByte;
  logic [15:0] laneHalf;

  assign memOp   = MemReadM | MemWriteM;
  assign isStore = MemWriteM;
  assign isLoad  = MemReadM & ~MemWriteM;
  assign size    = accSize(Funct3M);

`ifdef MISALIGN_TRAP_EN
  assign trap = memOp & (((size == SZ_H) & ALUResultM[0]) |
                         ((size == SZ_W) & (|ALUResultM[1:0])));
`else
  assign trap = 1'b0;
`endif
  assign slowOp = memOp & ~trap;

  // Misaligned halfword/word addresses are forced down to their natural boundary.
  always_comb begin
    effAddr = ALUResultM[AW+1:0];
    case (size)
      SZ_H:    effAddr[0] = 1'b0;
      SZ_W:    effAddr[1:0] = 2'b00;
      default: ;
    endcase
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    StallM    = 1'b0;
    case (state)
      S_IDLE: begin
        if (slowOp && !FlushM && (MEM_LATENCY > 1)) begin
          StallM    = 1'b1;
          stateNext = S_WAIT;
          cntNext   = CW'(MEM_LATENCY - 2);
        end
      end
      S_WAIT: begin
        if (FlushM) begin
          stateNext = S_IDLE;
        end else if (cnt != '0) begin
          StallM  = 1'b1;
          cntNext = cnt - CW'(1);
        end else begin
          stateNext = S_IDLE;
        end
      end
      default: stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    laneMask = '1;
    ramWdata = WriteDataM;
    case (size)
      SZ_B: begin
        laneMask = LANES'(1) << effAddr[1:0];
        ramWdata = {LANES{WriteDataM[7:0]}};
      end
      SZ_H: begin
        laneMask = LANES'(3) << {effAddr[1], 1'b0};
        ramWdata = {(LANES/2){WriteDataM[15:0]}};
      end
      default: ;
    endcase
  end

  // Nothing commits while stalled, flushed or in reset.
  assign commit = ~StallM & ~FlushM & ~rst;
  assign ramWe  = (commit & isStore & ~trap) ? laneMask : '0;

  byte_en_ram #(.XLEN(XLEN), .MEM_DEPTH(MEM_DEPTH)) uRam (
    .clk   (clk),
    .we    (ramWe),
    .addr  (effAddr[AW+1:2]),
    .wdata (ramWdata),
    .rdata (ramRdata)
  );

  assign laneByte = ramRdata[{effAddr[1:0], 3'b000} +: 8];
  assign laneHalf = ramRdata[{effAddr[1], 4'b0000} +: 16];

  always_comb begin
    case (Funct3M)
      LS_B:    loadExt = {{(XLEN-8){laneByte[7]}}, laneByte};
      LS_BU:   loadExt = {{(XLEN-8){1'b0}}, laneByte};
      LS_H:    loadExt = {{(XLEN-16){laneHalf[15]}}, laneHalf};
      LS_HU:   loadExt = {{(XLEN-16){1'b0}}, laneHalf};
      default: loadExt = ramRdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      RdW        <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
`ifdef MISALIGN_TRAP_EN
      MisalignW  <= 1'b0;
`endif
    end else if (StallM || FlushM) begin
      RdW        <= '0;
      RegWriteW  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      MisalignW  <= 1'b0;
`endif
    end else begin
      ALUResultW <= ALUResultM;
      ReadDataW  <= (isLoad && !trap) ? loadExt : '0;
      PCPlus4W   <= PCPlus4M;
      RdW        <= RdM;
      RegWriteW  <= RegWriteM & ~trap;
      ResultSrcW <= ResultSrcM;
`ifdef MISALIGN_TRAP_EN
      MisalignW  <= trap;
`endif
    end
  end

endmodule

// File: tb/tb_mem_wb_stage_ext.sv
// tb/tb_mem_wb_stage_ext.sv - self-checking bench: latency 1 and latency 3 instances against a byte-array model
module tb_mem_wb_stage_ext;

  typedef struct {
    logic [31:0] alu, wd, pc4;
    logic [4:0]  rd;
    logic        regW, memW, memR;
    logic [1:0]  res;
    logic [2:0]  f3;
  } opT;

  typedef struct {
    logic [31:0] alu, rdData, pc4;
    logic [4:0]  rd;
    logic        regW, mis, timeout;
    logic [1:0]  res;
    int          stalls, bubbleBad;
  } obsT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] aluM [2], wdM [2], pc4M [2];
  logic [4:0]  rdM [2];
  logic        regWM [2], memWM [2], memRM [2], flushM [2];
  logic [1:0]  resM [2];
  logic [2:0]  f3M [2];
  logic [31:0] aluW [2], rdDataW [2], pc4W [2];
  logic [4:0]  rdW [2];
  logic        regWW [2], stallM [2], misW [2];
  logic [1:0]  resW [2];

  int nCmp = 0;
  int nErr = 0;
  logic [7:0] refMem [2][4096];

  mem_wb_stage_ext #(.XLEN(32), .MEM_DEPTH(1024), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .ALUResultM(aluM[0]), .WriteDataM(wdM[0]), .PCPlus4M(pc4M[0]),
    .RdM(rdM[0]), .RegWriteM(regWM[0]), .MemWriteM(memWM[0]), .MemReadM(memRM[0]),
    .ResultSrcM(resM[0]), .Funct3M(f3M[0]), .FlushM(flushM[0]),
    .ALUResultW(aluW[0]), .ReadDataW(rdDataW[0]), .PCPlus4W(pc4W[0]), .RdW(rdW[0]),
    .RegWriteW(regWW[0]), .ResultSrcW(resW[0]),
`ifdef MISALIGN_TRAP_EN
    .MisalignW(misW[0]),
`endif
    .StallM(stallM[0]));

  mem_wb_stage_ext #(.XLEN(32), .MEM_DEPTH(1024), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .ALUResultM(aluM[1]), .WriteDataM(wdM[1]), .PCPlus4M(pc4M[1]),
    .RdM(rdM[1]), .RegWriteM(regWM[1]), .MemWriteM(memWM[1]), .MemReadM(memRM[1]),
    .ResultSrcM(resM[1]), .Funct3M(f3M[1]), .FlushM(flushM[1]),
    .ALUResultW(aluW[1]), .ReadDataW(rdDataW[1]), .PCPlus4W(pc4W[1]), .RdW(rdW[1]),
    .RegWriteW(regWW[1]), .ResultSrcW(resW[1]),
`ifdef MISALIGN_TRAP_EN
    .MisalignW(misW[1]),
`endif
    .StallM(stallM[1]));

`ifndef MISALIGN_TRAP_EN
  assign misW[0] = 1'b0;
  assign misW[1] = 1'b0;
`endif

  function automatic logic [11:0] effIdx(input logic [31:0] a, input logic [2:0] f3);
    logic [11:0] e;
    e = a[11:0];
    if (f3 == 3'b001 || f3 == 3'b101) e[0] = 1'b0;
    else if (f3 != 3'b000 && f3 != 3'b100) e[1:0] = 2'b00;
    return e;
  endfunction

  function automatic logic misaligned(input logic [31:0] a, input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
    if (f3 == 3'b001 || f3 == 3'b101) return a[0];
    return a[1] | a[0];
  endfunction

  function automatic logic [31:0] refLoad(input int inst, input logic [31:0] a, input logic [2:0] f3);
    logic [11:0] e;
    logic [7:0] b0, b1;
    e = effIdx(a, f3);
    b0 = refMem[inst][e];
    case (f3)
      3'b000: return {{24{b0[7]}}, b0};
      3'b100: return {24'h0, b0};
      3'b001: begin b1 = refMem[inst][e + 12'd1]; return {{16{b1[7]}}, b1, b0}; end
      3'b101: begin b1 = refMem[inst][e + 12'd1]; return {16'h0, b1, b0}; end
      default: return {refMem[inst][e + 12'd3], refMem[inst][e + 12'd2], refMem[inst][e + 12'd1], b0};
    endcase
  endfunction

  task automatic refStore(input int inst, input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    logic [11:0] e;
    e = effIdx(a, f3);
    refMem[inst][e] = d[7:0];
    if (f3 == 3'b001 || f3 == 3'b101) begin
      refMem[inst][e + 12'd1] = d[15:8];
    end else if (f3 != 3'b000 && f3 != 3'b100) begin
      refMem[inst][e + 12'd1] = d[15:8];
      refMem[inst][e + 12'd2] = d[23:16];
      refMem[inst][e + 12'd3] = d[31:24];
    end
  endtask

  function automatic opT mkOp(input logic memR, input logic memW, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    opT o;
    o.alu = a; o.wd = d; o.pc4 = $urandom; o.rd = rd; o.regW = memR;
    o.memW = memW; o.memR = memR; o.res = 2'($urandom_range(0, 3)); o.f3 = f3;
    return o;
  endfunction

  task automatic driveIdle(input int inst);
    aluM[inst] = '0; wdM[inst] = '0; pc4M[inst] = '0; rdM[inst] = '0; regWM[inst] = 1'b0;
    memWM[inst] = 1'b0; memRM[inst] = 1'b0; resM[inst] = '0; f3M[inst] = '0; flushM[inst] = 1'b0;
  endtask

  task automatic driveOp(input int inst, input opT op);
    aluM[inst] = op.alu; wdM[inst] = op.wd; pc4M[inst] = op.pc4; rdM[inst] = op.rd;
    regWM[inst] = op.regW; memWM[inst] = op.memW; memRM[inst] = op.memR;
    resM[inst] = op.res; f3M[inst] = op.f3; flushM[inst] = 1'b0;
  endtask

  // Presents one op, holds it through any stall cycles and captures the completing W slot.
  task automatic runOp(input int inst, input opT op, output obsT o);
    logic st;
    o.stalls = 0; o.bubbleBad = 0; o.timeout = 1'b1;
    o.alu = '0; o.rdData = '0; o.pc4 = '0; o.rd = '0; o.regW = 1'b0; o.res = '0; o.mis = 1'b0;
    @(negedge clk);
    driveOp(inst, op);
    #1;
    for (int c = 0; c < 8; c++) begin
      st = stallM[inst];
      @(posedge clk);
      #1;
      if (st) begin
        o.stalls++;
        if (regWW[inst] !== 1'b0 || rdW[inst] !== 5'd0) o.bubbleBad++;
      end else begin
        o.alu = aluW[inst]; o.rdData = rdDataW[inst]; o.pc4 = pc4W[inst]; o.rd = rdW[inst];
        o.regW = regWW[inst]; o.res = resW[inst]; o.mis = misW[inst]; o.timeout = 1'b0;
        break;
      end
    end
    driveIdle(inst);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      nCmp++;
      if ({aluW[i], rdDataW[i], pc4W[i], rdW[i], regWW[i], resW[i], misW[i]} !== '0) begin
        nErr++;
        $display("FAIL reset_w inst%0d: alu=%h rd=%h pc4=%h rdW=%0d regW=%b res=%0d, required all 0",
                 i, aluW[i], rdDataW[i], pc4W[i], rdW[i], regWW[i], resW[i]);
      end
      nCmp++;
      if (stallM[i] !== 1'b0) begin
        nErr++; $display("FAIL reset_stall inst%0d: got %b, required 0", i, stallM[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_latency1;
    obsT o;
    runOp(0, mkOp(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0), o);
    refStore(0, 32'h10, 3'b010, 32'hDEADBEEF);
    nCmp++;
    if (o.stalls !== 0 || o.timeout !== 1'b0) begin
      nErr++; $display("FAIL lat1_sw_stall: stalls=%0d timeout=%b, required 0/0", o.stalls, o.timeout);
    end
    runOp(0, mkOp(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd7), o);
    nCmp++;
    if (o.rdData !== 32'hDEADBEEF || o.stalls !== 0 || o.regW !== 1'b1 || o.rd !== 5'd7) begin
      nErr++;
      $display("FAIL lat1_lw: data=%h stalls=%0d regW=%b rd=%0d, required deadbeef/0/1/7",
               o.rdData, o.stalls, o.regW, o.rd);
    end
  endtask

  task automatic test_extension;
    obsT o;
    logic [31:0] addrs [4];
    logic [2:0]  f3s [4];
    logic [31:0] exps [4];
    addrs = '{32'h23, 32'h23, 32'h22, 32'h20};
    f3s   = '{3'b000, 3'b100, 3'b001, 3'b101};
    exps  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
    runOp(0, mkOp(1'b0, 1'b1, 3'b010, 32'h20, 32'h80FF7F01, 5'd0), o);
    refStore(0, 32'h20, 3'b010, 32'h80FF7F01);
    for (int i = 0; i < 4; i++) begin
      runOp(0, mkOp(1'b1, 1'b0, f3s[i], addrs[i], 32'h0, 5'd3), o);
      nCmp++;
      if (o.rdData !== exps[i]) begin
        nErr++;
        $display("FAIL ext f3=%b addr=%h: got %h, required %h", f3s[i], addrs[i], o.rdData, exps[i]);
      end
    end
  endtask

  task automatic test_latency3;
    obsT o;
    runOp(1, mkOp(1'b0, 1'b1, 3'b010, 32'h60, 32'hCAFEF00D, 5'd0), o);
    refStore(1, 32'h60, 3'b010, 32'hCAFEF00D);
    nCmp++;
    if (o.stalls !== 2 || o.bubbleBad !== 0) begin
      nErr++; $display("FAIL lat3_sw: stalls=%0d bubbleBad=%0d, required 2/0", o.stalls, o.bubbleBad);
    end
    runOp(1, mkOp(1'b1, 1'b0, 3'b010, 32'h60, 32'h0, 5'd9), o);
    nCmp++;
    if (o.stalls !== 2 || o.bubbleBad !== 0 || o.timeout !== 1'b0) begin
      nErr++;
      $display("FAIL lat3_lw_stall: stalls=%0d bubbleBad=%0d timeout=%b, required 2/0/0",
               o.stalls, o.bubbleBad, o.timeout);
    end
    nCmp++;
    if (o.rdData !== 32'hCAFEF00D || o.regW !== 1'b1 || o.rd !== 5'd9) begin
      nErr++;
      $display("FAIL lat3_lw_data: data=%h regW=%b rd=%0d, required cafef00d/1/9", o.rdData, o.regW, o.rd);
    end
  endtask

  task automatic test_flush;
    obsT o;
    runOp(1, mkOp(1'b0, 1'b1, 3'b010, 32'h30, 32'h11223344, 5'd0), o);
    refStore(1, 32'h30, 3'b010, 32'h11223344);
    @(negedge clk);
    driveOp(1, mkOp(1'b0, 1'b1, 3'b000, 32'h31, 32'h000000AA, 5'd4));
    regWM[1] = 1'b1;
    #1;
    nCmp++;
    if (stallM[1] !== 1'b1) begin nErr++; $display("FAIL flush_pre_stall: got %b, required 1", stallM[1]); end
    @(negedge clk);
    flushM[1] = 1'b1;
    #1;
    nCmp++;
    if (stallM[1] !== 1'b0) begin nErr++; $display("FAIL flush_stall: got %b, required 0", stallM[1]); end
    @(posedge clk);
    #1;
    nCmp++;
    if (regWW[1] !== 1'b0 || rdW[1] !== 5'd0) begin
      nErr++; $display("FAIL flush_bubble: regW=%b rd=%0d, required 0/0", regWW[1], rdW[1]);
    end
    driveIdle(1);
    runOp(1, mkOp(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 5'd2), o);
    nCmp++;
    if (o.rdData !== 32'h11223344 || o.stalls !== 2) begin
      nErr++; $display("FAIL flush_after: data=%h stalls=%0d, required 11223344/2", o.rdData, o.stalls);
    end
    runOp(0, mkOp(1'b0, 1'b1, 3'b010, 32'h34, 32'h01020304, 5'd0), o);
    refStore(0, 32'h34, 3'b010, 32'h01020304);
    @(negedge clk);
    driveOp(0, mkOp(1'b0, 1'b1, 3'b010, 32'h34, 32'h55555555, 5'd0));
    flushM[0] = 1'b1;
    @(posedge clk);
    #1;
    driveIdle(0);
    runOp(0, mkOp(1'b1, 1'b0, 3'b010, 32'h34, 32'h0, 5'd1), o);
    nCmp++;
    if (o.rdData !== 32'h01020304) begin
      nErr++; $display("FAIL flush_lat1: data=%h, required 01020304", o.rdData);
    end
  endtask

  task automatic test_reset_mid_op;
    obsT o;
    runOp(1, mkOp(1'b0, 1'b1, 3'b010, 32'h50, 32'hA5A5A5A5, 5'd0), o);
    refStore(1, 32'h50, 3'b010, 32'hA5A5A5A5);
    @(negedge clk);
    driveOp(1, mkOp(1'b0, 1'b1, 3'b010, 32'h50, 32'h5A5A5A5A, 5'd6));
    regWM[1] = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    nCmp++;
    if ({aluW[1], rdDataW[1], pc4W[1], rdW[1], regWW[1], resW[1]} !== '0) begin
      nErr++;
      $display("FAIL rst_mid_w: alu=%h rd=%h pc4=%h rdW=%0d regW=%b, required all 0",
               aluW[1], rdDataW[1], pc4W[1], rdW[1], regWW[1]);
    end
    driveIdle(1);
    rst = 1'b0;
    runOp(1, mkOp(1'b1, 1'b0, 3'b010, 32'h50, 32'h0, 5'd8), o);
    nCmp++;
    if (o.rdData !== 32'hA5A5A5A5 || o.stalls !== 2 || o.regW !== 1'b1) begin
      nErr++;
      $display("FAIL rst_mid_after: data=%h stalls=%0d regW=%b, required a5a5a5a5/2/1",
               o.rdData, o.stalls, o.regW);
    end
  endtask

  task automatic test_misalign;
    obsT o;
    runOp(1, mkOp(1'b0, 1'b1, 3'b010, 32'h40, 32'h0BADC0DE, 5'd0), o);
    refStore(1, 32'h40, 3'b010, 32'h0BADC0DE);
`ifdef MISALIGN_TRAP_EN
    runOp(1, mkOp(1'b1, 1'b0, 3'b010, 32'h42, 32'h0, 5'd5), o);
    nCmp++;
    if (o.mis !== 1'b1 || o.regW !== 1'b0 || o.stalls !== 0) begin
      nErr++;
      $display("FAIL misalign_trap: mis=%b regW=%b stalls=%0d, required 1/0/0", o.mis, o.regW, o.stalls);
    end
`else
    runOp(1, mkOp(1'b1, 1'b0, 3'b010, 32'h42, 32'h0, 5'd5), o);
    nCmp++;
    if (o.rdData !== 32'h0BADC0DE || o.regW !== 1'b1) begin
      nErr++; $display("FAIL misalign_lw: data=%h regW=%b, required 0badc0de/1", o.rdData, o.regW);
    end
    runOp(1, mkOp(1'b0, 1'b1, 3'b001, 32'h41, 32'h1234BEEF, 5'd0), o);
    refStore(1, 32'h41, 3'b001, 32'h1234BEEF);
    runOp(1, mkOp(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd5), o);
    nCmp++;
    if (o.rdData !== 32'h0BADBEEF) begin
      nErr++; $display("FAIL misalign_sh: data=%h, required 0badbeef", o.rdData);
    end
`endif
  endtask

  // Fill the low 256 bytes, then random mixed ops with random upper address bits (wrap-around).
  task automatic test_back_to_back;
    obsT o;
    opT op;
    logic [2:0] ldF3 [5];
    logic [31:0] expRd;
    logic trapExp, memOp;
    int expStalls, kind;
    ldF3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int inst = 0; inst < 2; inst++) begin
      for (int n = 0; n < 124; n++) begin
        if (n < 64) begin
          op = mkOp(1'b0, 1'b1, 3'b010, 32'(n * 4), $urandom, 5'd0);
        end else begin
          kind = $urandom_range(0, 3);
          op = mkOp(kind == 0 || kind == 3, kind == 1 || kind == 3, 3'b010,
                    ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255)), $urandom,
                    5'($urandom_range(0, 31)));
          op.regW = 1'($urandom_range(0, 1));
          op.f3 = op.memW ? 3'($urandom_range(0, 2)) : ldF3[$urandom_range(0, 4)];
        end
        memOp = op.memR | op.memW;
`ifdef MISALIGN_TRAP_EN
        trapExp = memOp & misaligned(op.alu, op.f3);
`else
        trapExp = 1'b0;
`endif
        expStalls = (memOp && inst == 1 && !trapExp) ? 2 : 0;
        expRd = (op.memR && !op.memW && !trapExp) ? refLoad(inst, op.alu, op.f3) : 32'h0;
        if (op.memW && !trapExp) refStore(inst, op.alu, op.f3, op.wd);
        runOp(inst, op, o);
        nCmp++;
        if (o.timeout !== 1'b0 || o.stalls !== expStalls || o.bubbleBad !== 0) begin
          nErr++;
          $display("FAIL rand_timing inst%0d n%0d: stalls=%0d bubbleBad=%0d timeout=%b, required %0d/0/0",
                   inst, n, o.stalls, o.bubbleBad, o.timeout, expStalls);
        end
        nCmp++;
        if (o.rdData !== expRd) begin
          nErr++;
          $display("FAIL rand_data inst%0d n%0d addr=%h f3=%b: got %h, required %h",
                   inst, n, op.alu, op.f3, o.rdData, expRd);
        end
        nCmp++;
        if ({o.alu, o.pc4, o.rd, o.regW, o.res, o.mis} !==
            {op.alu, op.pc4, op.rd, op.regW & ~trapExp, op.res, trapExp}) begin
          nErr++;
          $display("FAIL rand_pass inst%0d n%0d: alu=%h pc4=%h rd=%0d regW=%b res=%0d mis=%b, required %h/%h/%0d/%b/%0d/%b",
                   inst, n, o.alu, o.pc4, o.rd, o.regW, o.res, o.mis,
                   op.alu, op.pc4, op.rd, op.regW & ~trapExp, op.res, trapExp);
        end
      end
    end
  endtask

  initial begin
    driveIdle(0);
    driveIdle(1);
    test_reset;
    test_latency1;
    test_extension;
    test_latency3;
    test_flush;
    test_reset_mid_op;
    test_misalign;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
